// File: rtl/ks8_sub32_pkg.sv
// ----------------------------------------------------------------------------
// ks8_sub32_pkg
// Shared definitions for the slice-pipelined subtractor:
//   SLICE_W    width of one adder slice (8)
//   NUM_SLICES default slice / stage count (4)
//   DATA_W     full operand width (32)
//   stage_t    per-stage register record: valid, carry, the operand slices
//              still to be processed, and the result slices already produced
//   upper_mask helper selecting the operand bits above a given slice
// ----------------------------------------------------------------------------
package ks8_sub32_pkg;

   localparam int SLICE_W    = 8;
   localparam int NUM_SLICES = 4;
   localparam int DATA_W     = SLICE_W * NUM_SLICES;

   typedef struct packed {
      logic              valid;
      logic              carry;  // carry-out of the slice this stage processed
      logic [DATA_W-1:0] a;      // minuend, processed slices cleared
      logic [DATA_W-1:0] b;      // subtrahend, processed slices cleared
      logic [DATA_W-1:0] r;      // difference, slices produced so far
   } stage_t;

   // Keeps only the bits above slice k, i.e. the slices later stages still need.
   function automatic logic [DATA_W-1:0] upper_mask(input int k);
      return {DATA_W{1'b1}} << (SLICE_W * (k + 1));
   endfunction

endpackage

// File: rtl/ks8_sub32_pipe_ks8.sv
// ----------------------------------------------------------------------------
// ks8
// 8-bit Kogge-Stone parallel-prefix adder.
//   a_i, b_i  8-bit addends
//   cin_i     carry-in
//   sum_o     8-bit sum
//   cout_o    carry-out
// ----------------------------------------------------------------------------
module ks8 (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       cin_i,
   output logic [7:0] sum_o,
   output logic       cout_o
);

   logic [7:0] p0, g0, g1, p1, g2, p2, g3;

   assign p0 = a_i ^ b_i;
   // Carry-in is folded into bit 0's generate so the prefix tree yields
   // true carries directly.
   assign g0 = (a_i & b_i) | {7'b0, p0[0] & cin_i};

   // Three prefix levels, spans 1, 2, 4. Zero shifted in at the bottom means
   // already-final positions are left untouched.
   assign g1 = g0 | (p0 & (g0 << 1));
   assign p1 = p0 & (p0 << 1);
   assign g2 = g1 | (p1 & (g1 << 2));
   assign p2 = p1 & (p1 << 2);
   assign g3 = g2 | (p2 & (g2 << 4));

   assign sum_o  = p0 ^ {g3[6:0], cin_i};
   assign cout_o = g3[7];

endmodule

// File: rtl/ks8_sub32_pipe.sv
// ----------------------------------------------------------------------------
// ks8_sub32_pipe
// Pipelined W-bit subtractor (W = 8*SLICES): d = x1 - x2 - bin, one 8-bit
// slice per stage, carry rippling stage to stage through registers.
//   clk, rst             clock, asynchronous active-high reset
//   x1, x2, bin          minuend, subtrahend, borrow-in
//   in_valid / in_ready  upstream handshake
//   d, bout, ovf, zero   difference, borrow-out, signed overflow, d == 0
//   out_valid/out_ready  downstream handshake
// Only SLICES = 4 is supported (stage record width is fixed by the package).
// ----------------------------------------------------------------------------
module ks8_sub32_pipe
   import ks8_sub32_pkg::*;
#(
   parameter int SLICES = NUM_SLICES
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [SLICE_W*SLICES-1:0] x1,
   input  logic [SLICE_W*SLICES-1:0] x2,
   input  logic                      bin,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [SLICE_W*SLICES-1:0] d,
   output logic                      bout,
   output logic                      ovf,
   output logic                      zero,
   output logic                      out_valid,
   input  logic                      out_ready
);

   localparam int W    = SLICE_W * SLICES;
   localparam int LAST = SLICES - 1;

   stage_t            s_q [SLICES];
   stage_t            s_d [SLICES];
   logic [SLICES-1:0] adv;

   logic [SLICE_W-1:0] add_a  [SLICES];
   logic [SLICE_W-1:0] add_b  [SLICES];
   logic [SLICE_W-1:0] add_s  [SLICES];
   logic               add_ci [SLICES];
   logic               add_co [SLICES];

   logic ovf_q, ovf_d, zero_q, zero_d;

   // Advance chain: a stage moves when empty or when the one below it moves,
   // so bubbles collapse under a downstream stall. Only out_ready is combinational.
   always_comb begin
      adv[LAST] = !s_q[LAST].valid || out_ready;
      for (int k = LAST - 1; k >= 0; k--) begin
         adv[k] = !s_q[k].valid || adv[k+1];
      end
   end

   // Subtraction as x1 + ~x2 + ~bin, one slice per stage.
   for (genvar k = 0; k < SLICES; k++) begin : g_slice
      if (k == 0) begin : g_first
         assign add_a[k]  = x1[SLICE_W-1:0];
         assign add_b[k]  = ~x2[SLICE_W-1:0];
         assign add_ci[k] = ~bin;
      end else begin : g_rest
         assign add_a[k]  = s_q[k-1].a[k*SLICE_W +: SLICE_W];
         assign add_b[k]  = ~s_q[k-1].b[k*SLICE_W +: SLICE_W];
         assign add_ci[k] = s_q[k-1].carry;
      end

      ks8 u_ks8 (
         .a_i    (add_a[k]),
         .b_i    (add_b[k]),
         .cin_i  (add_ci[k]),
         .sum_o  (add_s[k]),
         .cout_o (add_co[k])
      );
   end

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      for (int k = 0; k < SLICES; k++) begin
         s_d[k] = s_q[k];
      end
      ovf_d  = ovf_q;
      zero_d = zero_q;

      if (adv[0]) begin
         s_d[0].valid = in_valid;
         if (in_valid) begin
            s_d[0].carry              = add_co[0];
            s_d[0].a                  = x1 & upper_mask(0);
            s_d[0].b                  = x2 & upper_mask(0);
            s_d[0].r                  = '0;
            s_d[0].r[SLICE_W-1:0]     = add_s[0];
         end
      end

      for (int k = 1; k < SLICES; k++) begin
         if (adv[k]) begin
            s_d[k].valid = s_q[k-1].valid;
            // Bubbles only clear valid; data holds to avoid needless toggling.
            if (s_q[k-1].valid) begin
               s_d[k].carry                    = add_co[k];
               s_d[k].a                        = s_q[k-1].a & upper_mask(k);
               s_d[k].b                        = s_q[k-1].b & upper_mask(k);
               s_d[k].r                        = s_q[k-1].r;
               s_d[k].r[k*SLICE_W +: SLICE_W]  = add_s[k];
            end
         end
      end

      // Sign bits of the operands are gone after the last slice is processed,
      // so overflow and zero are resolved while loading the last stage.
      if (adv[LAST] && s_q[LAST-1].valid) begin
         ovf_d  = (s_q[LAST-1].a[W-1] != s_q[LAST-1].b[W-1]) &&
                  (add_s[LAST][SLICE_W-1] != s_q[LAST-1].a[W-1]);
         zero_d = (s_q[LAST-1].r[LAST*SLICE_W-1:0] == '0) && (add_s[LAST] == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: datapath registers are reset as well, because the outputs
         // they drive must read 0 while reset is held.
         for (int k = 0; k < SLICES; k++) begin
            s_q[k] <= '0;
         end
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         for (int k = 0; k < SLICES; k++) begin
            s_q[k] <= s_d[k];
         end
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = s_q[LAST].valid;
   assign d         = s_q[LAST].r[W-1:0];
   // Gated by valid so a reset (carry = 0) reads as no borrow.
   assign bout      = s_q[LAST].valid & ~s_q[LAST].carry;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_ks8_sub32_pipe.sv
// ----------------------------------------------------------------------------
// tb_ks8_sub32_pipe
// Self-checking bench for ks8_sub32_pipe: directed corner cases, backpressure,
// mid-flight reset, then a long random stream against an arithmetic model.
// ----------------------------------------------------------------------------
module tb_ks8_sub32_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] x1, x2;
   logic        bin;
   logic        in_valid, in_ready;
   logic [31:0] d;
   logic        bout, ovf, zero;
   logic        out_valid, out_ready;

   ks8_sub32_pipe #(.SLICES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .x1        (x1),
      .x2        (x2),
      .bin       (bin),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d         (d),
      .bout      (bout),
      .ovf       (ovf),
      .zero      (zero),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic        bout;
      logic        ovf;
      logic        zero;
   } res_t;

   res_t        exp_q[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          samp_cyc;
   logic        fired_in, fired_out, seen_valid, samp_in_ready;
   logic [31:0] samp_d;
   logic [2:0]  samp_flags;
   logic        prev_stall;
   logic [35:0] prev_out;

   // Reference: plain wide arithmetic on the operand values.
   function automatic res_t ref_sub(input logic [31:0] a, input logic [31:0] b,
                                    input logic bi);
      res_t        r;
      logic [32:0] u;
      longint      sd;
      u      = {1'b0, a} - {1'b0, b} - {32'b0, bi};
      r.d    = u[31:0];
      r.bout = u[32];
      sd     = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
      r.ovf  = (sd > 64'sh7FFFFFFF) || (sd < -64'sh80000000);
      r.zero = (r.d == 32'd0);
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock cycle: drive at edge+1, sample at edge+2, score handshakes.
   task automatic do_cycle(input logic iv, input logic [31:0] a,
                           input logic [31:0] b, input logic bi,
                           input logic ordy, input string tag);
      res_t e;
      in_valid  = iv;
      x1        = a;
      x2        = b;
      bin       = bi;
      out_ready = ordy;
      #1;
      check({tag, "_in_ready"}, in_ready, (exp_q.size() < 4) || ordy);
      if (prev_stall)
         check({tag, "_hold"}, {out_valid, d, bout, ovf, zero}, prev_out);
      samp_cyc      = cyc;
      samp_in_ready = in_ready;
      samp_d        = d;
      samp_flags    = {bout, ovf, zero};
      seen_valid    = out_valid;
      fired_in      = iv && in_ready;
      fired_out     = out_valid && ordy;
      if (fired_out) begin
         if (exp_q.size() == 0) begin
            check({tag, "_spurious"}, out_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check({tag, "_d"}, d, e.d);
            check({tag, "_flags"}, {bout, ovf, zero}, {e.bout, e.ovf, e.zero});
         end
      end
      if (fired_in) exp_q.push_back(ref_sub(a, b, bi));
      prev_stall = out_valid && !ordy;
      prev_out   = {out_valid, d, bout, ovf, zero};
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Single operation into an empty pipe: explicit expected values and latency.
   task automatic directed(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic bi,
                           input logic [31:0] ed, input logic eb,
                           input logic eo, input logic ez);
      int   t_acc;
      logic got;
      got   = 1'b0;
      t_acc = 0;
      for (int n = 0; n < 20 && !got; n++) begin
         do_cycle(1'b1, a, b, bi, 1'b1, tag);
         if (fired_in) begin
            got   = 1'b1;
            t_acc = samp_cyc;
         end
      end
      check({tag, "_accepted"}, got, 1'b1);
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         do_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, tag);
         if (seen_valid) begin
            got = 1'b1;
            check({tag, "_latency"}, samp_cyc - t_acc, 4);
            check({tag, "_const_d"}, samp_d, ed);
            check({tag, "_const_flags"}, samp_flags, {eb, eo, ez});
         end
      end
      check({tag, "_out_seen"}, got, 1'b1);
   endtask

   initial begin
      int          sent;
      int          acc_before_stall;
      int          pops_after;
      int          stale;
      logic        iv, ordy, bi;
      logic [31:0] a, b;
      logic [31:0] bp_a [8];
      logic [31:0] bp_b [8];

      // ---- reset state ----
      rst        = 1'b1;
      in_valid   = 1'b0;
      x1         = 32'd0;
      x2         = 32'd0;
      bin        = 1'b0;
      out_ready  = 1'b0;
      prev_stall = 1'b0;
      prev_out   = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_d", d, 32'd0);
      check("rst_flags", {bout, ovf, zero}, 3'b000);
      check("rst_in_ready", in_ready, 1'b1);
      rst = 1'b0;

      // ---- directed corner cases ----
      directed("basic",   32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
      directed("borrow",  32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      directed("xslice",  32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
      directed("ovf",     32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
      directed("zero",    32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
      directed("zero_bi", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

      // ---- backpressure: 8 operands, out_ready low from cycle 2 to 11 ----
      for (int i = 0; i < 8; i++) begin
         bp_a[i] = $urandom;
         bp_b[i] = $urandom;
      end
      sent             = 0;
      acc_before_stall = -1;
      pops_after       = 0;
      for (int c = 0; c < 40 && (sent < 8 || exp_q.size() > 0); c++) begin
         ordy = (c < 2) || (c >= 12);
         do_cycle(sent < 8, bp_a[(sent < 8) ? sent : 7], bp_b[(sent < 8) ? sent : 7],
                  1'(c & 1), ordy, "bp");
         if (!samp_in_ready && acc_before_stall < 0) acc_before_stall = sent;
         if (fired_in) sent++;
         if (c >= 12 && c < 20 && fired_out) pops_after++;
      end
      check("bp_accepts_before_stall", acc_before_stall, 4);
      check("bp_gapless_drain", pops_after, 8);
      check("bp_sent", sent, 8);
      check("bp_drained", exp_q.size(), 0);

      // ---- reset mid-flight ----
      for (int i = 0; i < 3; i++) do_cycle(1'b1, $urandom, $urandom, 1'b0, 1'b1, "mid");
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_d", d, 32'd0);
      check("midrst_flags", {bout, ovf, zero}, 3'b000);
      check("midrst_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      prev_stall = 1'b0;
      stale      = 0;
      for (int i = 0; i < 8; i++) begin
         do_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, "postrst");
         if (seen_valid) stale++;
      end
      check("postrst_no_stale", stale, 0);
      directed("postrst_op", 32'hDEAD_BEEF, 32'h0000_BEEF, 1'b0, 32'hDEAD_0000, 1'b0, 1'b0, 1'b0);

      // ---- random stream ----
      sent = 0;
      for (int c = 0; c < 60000 && (sent < 10000 || exp_q.size() > 0); c++) begin
         iv   = (sent < 10000) && ($urandom_range(0, 9) < 7);
         a    = $urandom;
         b    = ($urandom_range(0, 15) == 0) ? a : $urandom;
         bi   = 1'($urandom_range(0, 1));
         ordy = ($urandom_range(0, 9) < 7);
         do_cycle(iv, a, b, bi, ordy, "rnd");
         if (fired_in) sent++;
      end
      check("rnd_sent", sent, 10000);
      check("rnd_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ks8_sub32_pipe.md
KS8_SUB32_PIPE -- requirements
Module: ks8_sub32_pipe

Interface
REQ-001 Parameter: SLICES, default 4, number of 8-bit slices and pipeline stages; operand width W = 8*SLICES; only 4 is required to be supported.
REQ-002 clk  input  1  single clock for all state; every register updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 x1  input  W  minuend.
REQ-005 x2  input  W  subtrahend.
REQ-006 bin  input  1  borrow-in, weight 1 at the LSB.
REQ-007 in_valid / in_ready  input / output  1 / 1  upstream handshake; an operand is accepted on a cycle where both are 1.
REQ-008 d  output  W  difference x1 - x2 - bin, modulo 2^W.
REQ-009 bout  output  1  borrow-out; 1 iff x1 < x2 + bin as unsigned values.
REQ-010 ovf  output  1  signed overflow of the two's-complement subtraction.
REQ-011 zero  output  1  1 iff d == 0.
REQ-012 out_valid / out_ready  output / input  1 / 1  downstream handshake; a result is consumed on a cycle where both are 1.

Function
REQ-013 Each slice SHALL compute one 8-bit add of x1 slice + ~x2 slice + carry.
REQ-014 Carry into slice 0 SHALL be ~bin.
REQ-015 Stage k SHALL process slice k; its carry-out SHALL be registered with the stage data and feed slice k+1 in stage k+1.
REQ-016 Each stage SHALL register the operand slices it has not yet processed, the result slices already produced, the carry, and one valid bit.
REQ-017 bout SHALL equal ~(carry-out of the last slice).
REQ-018 ovf SHALL equal (x1[W-1] != x2[W-1]) && (d[W-1] != x1[W-1]).
REQ-019 d, bout, ovf and zero SHALL be driven from the last stage's registers, with no combinational path from x1/x2 to these outputs.
REQ-020 Latency: an operand accepted in cycle t SHALL produce out_valid=1 with its result in cycle t+SLICES when no stall occurs.
REQ-021 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-022 Stage k SHALL advance when it is empty or when stage k+1 advances this cycle; the last stage advances when !out_valid or out_ready.
REQ-023 in_ready SHALL equal the stage-0 advance condition; in_ready SHALL be combinational from out_ready, and no other handshake path is combinational.
REQ-024 When out_valid=1 and out_ready=0, d, bout, ovf, zero and out_valid SHALL hold stable until consumed.
REQ-025 With all stages full and out_ready=0, in_ready SHALL be 0 and no operand SHALL be lost or duplicated.
REQ-026 Simultaneous accept at the input and consume at the output when the pipeline is full SHALL be permitted with no bubble.
REQ-027 Results SHALL emerge in acceptance order.
REQ-028 Stages that do not advance SHALL hold their contents; bubbles SHALL collapse when downstream stalls.

Reset
REQ-029 While rst=1, all stage valid bits, carries, data registers, out_valid, d, bout, ovf and zero SHALL be 0.
REQ-030 While rst=1, in_ready SHALL be 1.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations; no result SHALL appear for them after reset deasserts.
REQ-032 The first operand accepted after reset SHALL follow REQ-020 exactly.

Structure
REQ-033 A shared package SHALL hold the SLICE_W=8 constant and the per-stage register record type (valid, carry, operand slices, result slices).
REQ-034 The existing ks8 8-bit Kogge-Stone adder SHALL be instantiated once per stage as the only sub-module, with inputs x1 slice, ~x2 slice and the registered carry.
REQ-035 Flag logic and handshake logic SHALL live in the top module.

Verification
REQ-036 Basic subtract: x1=0x00000005, x2=0x00000003, bin=0 -> d=0x00000002, bout=0, ovf=0, zero=0, out_valid exactly 4 cycles after accept.
REQ-037 Borrow out: x1=0x00000000, x2=0x00000001 -> d=0xFFFFFFFF, bout=1, ovf=0; and x1=0x00000100, x2=0x00000001 -> d=0x000000FF, exercising cross-slice borrow.
REQ-038 Signed overflow and zero: x1=0x80000000, x2=0x00000001 -> d=0x7FFFFFFF, ovf=1, bout=0; and x1=x2=0x12345678, bin=0 -> d=0, zero=1; and same operands with bin=1 -> d=0xFFFFFFFF, bout=1.
REQ-039 Backpressure: stream 8 consecutive operands with out_ready=0 from cycle 2 -> in_ready falls after 4 accepts; output holds stable; releasing out_ready yields all 8 results in order with no gaps.
REQ-040 Reset mid-flight: accept 3 operands, assert rst for 1 cycle -> all outputs 0 and no stale results appear; the next operand appears after 4 cycles.
REQ-041 Randomized check: 10k random x1/x2/bin with random in_valid/out_ready -> every result matches a reference model (x1 - x2 - bin, with bout, ovf and zero) in order.
